// File: rtl/display_scheduler.sv
// Purpose : shares one 8-digit seven-segment driver between the live timer, score flash and end-of-game banner.
// Latency : every output is registered; a LIVE input change shows one cycle later, and a request is acted on from the next edge.
// Backpres: none; requests are one-cycle pulses held in pending flags until their view is entered.
//
// Ports:
//   i_clk, i_reset            : clock and synchronous active-high reset
//   i_time_val, i_score_val   : live timer value and current score
//   i_score_req, i_banner_req : one-cycle request pulses; i_banner_win is sampled with i_banner_req
//   o_score_ack, o_banner_ack : one-cycle pulse on the first cycle of the SCORE / BANNER view
//   o_disp_number, o_disp_score, o_disp_blank : display driver inputs
//   o_view                    : 0 LIVE, 1 GAP, 2 SCORE, 3 BANNER
// Optional macro BANNER_LATCH_EN: BANNER is held until reset, and requests are ignored while in it.
module display_scheduler #(
  parameter int GAP_CYCLES    = 5_000_000,
  parameter int SCORE_CYCLES  = 50_000_000,
  parameter int BANNER_CYCLES = 150_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_time_val,
  input  logic [1:0]  i_score_val,
  input  logic        i_score_req,
  input  logic        i_banner_req,
  input  logic        i_banner_win,
  output logic        o_score_ack,
  output logic        o_banner_ack,
  output logic [15:0] o_disp_number,
  output logic [1:0]  o_disp_score,
  output logic        o_disp_blank,
  output logic [1:0]  o_view
);

  localparam int MAX_GS  = (GAP_CYCLES > SCORE_CYCLES) ? GAP_CYCLES : SCORE_CYCLES;
  localparam int MAX_ALL = (MAX_GS > BANNER_CYCLES) ? MAX_GS : BANNER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_CYCLES - 1);
`ifndef BANNER_LATCH_EN
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_LIVE   = 2'd0,
    S_GAP    = 2'd1,
    S_SCORE  = 2'd2,
    S_BANNER = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_score_pend;
  logic               r_banner_pend;
  logic               r_win_q;
  logic               r_score_ack;
  logic               r_banner_ack;
  logic [15:0]        r_disp_number;
  logic [1:0]         r_disp_score;
  logic               r_disp_blank;

  logic               w_score_req;
  logic               w_banner_req;
  logic               w_score_eff;
  logic               w_banner_eff;
  logic               w_win_eff;
  logic               w_expire;
  logic               w_score_enter;
  logic               w_banner_enter;
  logic [15:0]        w_nxt_number;
  logic [1:0]         w_nxt_score;
  logic               w_nxt_blank;

`ifdef BANNER_LATCH_EN
  // Game over: once the banner is up, nothing else may claim the display.
  assign w_score_req  = i_score_req  & (r_state != S_BANNER);
  assign w_banner_req = i_banner_req & (r_state != S_BANNER);
`else
  assign w_score_req  = i_score_req;
  assign w_banner_req = i_banner_req;
`endif

  // A request is acted on in the same cycle it arrives, as if its flag were already set.
  assign w_score_eff  = r_score_pend  | w_score_req;
  assign w_banner_eff = r_banner_pend | w_banner_req;
  assign w_win_eff    = w_banner_req ? i_banner_win : r_win_q;

  always_comb begin
    w_expire = 1'b0;
    case (r_state)
      S_GAP:    w_expire = (r_cnt == GAP_LAST);
      S_SCORE:  w_expire = (r_cnt == SCORE_LAST);
`ifdef BANNER_LATCH_EN
      S_BANNER: w_expire = 1'b0;
`else
      S_BANNER: w_expire = (r_cnt == BANNER_LAST);
`endif
      default:  w_expire = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LIVE:   if (w_score_eff || w_banner_eff) w_next = S_GAP;
      S_GAP:    if (w_expire) w_next = w_banner_eff ? S_BANNER : S_SCORE;
      // A pending banner preempts a running score flash at once.
      S_SCORE:  if (w_banner_eff) w_next = S_GAP;
                else if (w_expire) w_next = w_score_eff ? S_GAP : S_LIVE;
      S_BANNER: if (w_expire) w_next = (w_banner_eff || w_score_eff) ? S_GAP : S_LIVE;
      default:  w_next = S_LIVE;
    endcase
  end

  assign w_score_enter  = (w_next == S_SCORE)  && (r_state != S_SCORE);
  assign w_banner_enter = (w_next == S_BANNER) && (r_state != S_BANNER);

  // Output logic: values the display registers take on the coming edge.
  always_comb begin
    w_nxt_number = r_disp_number;
    w_nxt_score  = r_disp_score;
    w_nxt_blank  = 1'b1;
    case (w_next)
      S_LIVE: begin
        w_nxt_number = i_time_val;
        w_nxt_score  = i_score_val;
        w_nxt_blank  = 1'b0;
      end
      S_SCORE: begin
        w_nxt_blank = 1'b0;
        if (w_score_enter) begin
          w_nxt_number = i_time_val;
          w_nxt_score  = i_score_val;
        end
      end
      S_BANNER: begin
        w_nxt_blank = 1'b0;
        if (w_banner_enter) begin
          // The driver shows win text for number 4 and lose text for score 0.
          if (w_win_eff) begin
            w_nxt_number = 16'd4;
            w_nxt_score  = i_score_val;
          end else begin
            w_nxt_number = i_time_val;
            w_nxt_score  = 2'd0;
          end
        end
      end
      default: begin
        w_nxt_blank = 1'b1;
      end
    endcase
  end

  // State register, dwell counter, pending flags and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_LIVE;
      r_cnt         <= '0;
      r_score_pend  <= 1'b0;
      r_banner_pend <= 1'b0;
      r_win_q       <= 1'b0;
      r_score_ack   <= 1'b0;
      r_banner_ack  <= 1'b0;
      r_disp_number <= 16'd0;
      r_disp_score  <= 2'd0;
      r_disp_blank  <= 1'b1;
    end else begin
      r_state <= w_next;
      // LIVE has no dwell, so its counter idles at zero.
      r_cnt   <= ((w_next != r_state) || (w_next == S_LIVE)) ? '0 : r_cnt + 1'b1;
      // A new request in the same cycle as the clear keeps the flag set.
      r_score_pend  <= w_score_req  | (r_score_pend  & ~w_score_enter);
      r_banner_pend <= w_banner_req | (r_banner_pend & ~w_banner_enter);
      r_win_q       <= w_win_eff;
      r_score_ack   <= w_score_enter;
      r_banner_ack  <= w_banner_enter;
      r_disp_number <= w_nxt_number;
      r_disp_score  <= w_nxt_score;
      r_disp_blank  <= w_nxt_blank;
    end
  end

  assign o_view        = r_state;
  assign o_score_ack   = r_score_ack;
  assign o_banner_ack  = r_banner_ack;
  assign o_disp_number = r_disp_number;
  assign o_disp_score  = r_disp_score;
  assign o_disp_blank  = r_disp_blank;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

  localparam int GAP_C    = 2;
  localparam int SCORE_C  = 5;
  localparam int BANNER_C = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] time_val = 16'd0;
  logic [1:0]  score_val = 2'd0;
  logic        score_req = 1'b0;
  logic        banner_req = 1'b0;
  logic        banner_win = 1'b0;
  logic        score_ack;
  logic        banner_ack;
  logic [15:0] disp_number;
  logic [1:0]  disp_score;
  logic        disp_blank;
  logic [1:0]  view;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scheduler #(
    .GAP_CYCLES(GAP_C), .SCORE_CYCLES(SCORE_C), .BANNER_CYCLES(BANNER_C)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_time_val(time_val), .i_score_val(score_val),
    .i_score_req(score_req), .i_banner_req(banner_req), .i_banner_win(banner_win),
    .o_score_ack(score_ack), .o_banner_ack(banner_ack), .o_disp_number(disp_number),
    .o_disp_score(disp_score), .o_disp_blank(disp_blank), .o_view(view)
  );

  // Reference model: view plus cycles remaining in it, pending requests and displayed values.
  int          m_view, m_left;
  logic        m_sp, m_bp, m_win, m_blank, m_sack, m_back;
  logic [15:0] m_num;
  logic [1:0]  m_scr;

  function automatic int dwell(input int v);
    if (v == 1) return GAP_C;
    if (v == 2) return SCORE_C;
    if (v == 3) return BANNER_C;
    return 0;
  endfunction

  task automatic model_update(input logic r, sq_in, bq_in, bw, input logic [15:0] t, input logic [1:0] s);
    int nv;
    logic sq, bq, sp, bp, win;
    if (r) begin
      m_view = 0; m_left = 0; m_sp = 0; m_bp = 0; m_win = 0;
      m_blank = 1; m_num = 0; m_scr = 0; m_sack = 0; m_back = 0;
      return;
    end
    sq = sq_in; bq = bq_in;
`ifdef BANNER_LATCH_EN
    if (m_view == 3) begin sq = 0; bq = 0; end
`endif
    sp = m_sp | sq;
    bp = m_bp | bq;
    win = bq ? bw : m_win;
    nv = m_view;
    if (m_view == 0) nv = (sp || bp) ? 1 : 0;
    else if (m_view == 1) nv = (m_left == 1) ? (bp ? 3 : 2) : 1;
    else if (m_view == 2) nv = bp ? 1 : ((m_left == 1) ? (sp ? 1 : 0) : 2);
    else begin
`ifdef BANNER_LATCH_EN
      nv = 3;
`else
      nv = (m_left == 1) ? ((bp || sp) ? 1 : 0) : 3;
`endif
    end
    m_sack = (nv == 2) && (m_view != 2);
    m_back = (nv == 3) && (m_view != 3);
    m_blank = (nv == 1);
    if (nv == 0) begin m_num = t; m_scr = s; end
    if (m_sack) begin m_num = t; m_scr = s; end
    if (m_back) begin
      m_num = win ? 16'd4 : t;
      m_scr = win ? s : 2'd0;
    end
    m_left = (nv != m_view) ? dwell(nv) : m_left - 1;
    m_sp = m_sack ? sq : sp;
    m_bp = m_back ? bq : bp;
    m_win = win;
    m_view = nv;
  endtask

  function automatic logic [22:0] dut_vec();
    return {view, disp_blank, disp_number, disp_score, score_ack, banner_ack};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got view=%0d blank=%0d num=%0d score=%0d sack=%0d back=%0d, want view=%0d blank=%0d num=%0d score=%0d sack=%0d back=%0d",
               name, act[22:21], act[20], act[19:4], act[3:2], act[1], act[0],
               exp[22:21], exp[20], exp[19:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare the DUT against the model.
  task automatic step(input logic r, sq, bq, bw, input logic [15:0] t, input logic [1:0] s);
    rst = r; score_req = sq; banner_req = bq; banner_win = bw; time_val = t; score_val = s;
    @(posedge clk);
    model_update(r, sq, bq, bw, t, s);
    #1;
    check("model", dut_vec(), {m_view[1:0], m_blank, m_num, m_scr, m_sack, m_back});
  endtask

  typedef struct {
    logic        r, sq, bq, bw;
    logic [15:0] t;
    logic [1:0]  s;
    logic [22:0] exp;
  } vec_t;

  function automatic vec_t mk(input int r, sq, bq, bw, t, s, v, bl, num, scr, sa, ba);
    vec_t x;
    x.r = r[0]; x.sq = sq[0]; x.bq = bq[0]; x.bw = bw[0];
    x.t = t[15:0]; x.s = s[1:0];
    x.exp = {v[1:0], bl[0], num[15:0], scr[1:0], sa[0], ba[0]};
    return x;
  endfunction

  vec_t tbl[11];

  initial begin
    int sa, ba, v;
    //              r sq bq bw   t  s   v bl num scr sa ba
    tbl[0]  = mk(1, 0, 0, 0, 123, 2,  0, 1,   0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 123, 2,  0, 0, 123, 2, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,  45, 3,  0, 0,  45, 3, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,  45, 3,  1, 1,  45, 3, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,  45, 3,  1, 1,  45, 3, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  45, 3,  2, 0,  45, 3, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0,  60, 1,  2, 0,  45, 3, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,  60, 1,  2, 0,  45, 3, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,  60, 1,  2, 0,  45, 3, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,  60, 1,  2, 0,  45, 3, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,  61, 1,  0, 0,  61, 1, 0, 0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].sq, tbl[i].bq, tbl[i].bw, tbl[i].t, tbl[i].s);
      check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

`ifndef BANNER_LATCH_EN
    // Simultaneous requests: GAP, win BANNER, GAP, SCORE, LIVE.
    sa = 0; ba = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i == 0, i == 0, 1'b1, 16'd77, 2'd2);
      v = (i < 2) ? 1 : (i < 10) ? 3 : (i < 12) ? 1 : (i < 17) ? 2 : 0;
      check_int($sformatf("both_view[%0d]", i), int'(view), v);
      if (view == 2'd3) check_int("both_win_num", int'(disp_number), 4);
      sa += int'(score_ack); ba += int'(banner_ack);
    end
    check_int("both_sack_count", sa, 1);
    check_int("both_back_count", ba, 1);

    // Lose banner preempting the 2nd cycle of a score flash; no second score view.
    sa = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i == 0, i == 4, 1'b0, 16'd300, 2'd1);
      v = (i < 2) ? 1 : (i < 4) ? 2 : (i < 6) ? 1 : (i < 14) ? 3 : 0;
      check_int($sformatf("preempt_view[%0d]", i), int'(view), v);
      if (view == 2'd3) check_int("preempt_lose_score", int'(disp_score), 0);
      sa += int'(score_ack);
    end
    check_int("preempt_sack_count", sa, 1);
`endif

    // Reset on the 3rd BANNER cycle with a score request still pending.
    for (int i = 0; i < 5; i++) step(1'b0, i == 0, i == 0, 1'b1, 16'd500, 2'd3);
    check_int("rst_pre_view", int'(view), 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd500, 2'd3);
    check("rst_mid_banner", dut_vec(), {2'd0, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0});
    sa = 0; ba = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'd500, 2'd3);
      sa += int'(score_ack); ba += int'(banner_ack);
      check_int("rst_after_view", int'(view), 0);
    end
    check_int("rst_no_acks", sa + ba, 0);

`ifdef BANNER_LATCH_EN
    sa = 0;
    for (int i = 0; i < 130; i++) begin
      step(1'b0, i == 60, i == 0 || i == 70, 1'b1, 16'd9, 2'd1);
      if (i >= 2) check_int("latch_view", int'(view), 3);
      if (i > 2) sa += int'(score_ack) + int'(banner_ack);
    end
    check_int("latch_no_acks", sa, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd9, 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 2'd1);
    check_int("latch_reset_live", int'(view), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(299) == 0, $urandom_range(39) == 0, $urandom_range(59) == 0,
           1'($urandom), 16'($urandom_range(999)), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
